// File: rtl/stack_pkg.sv
// Shared definitions for the stack, its command sequencer and the top level:
// opcodes, sequencer state encoding and default geometry.
package stack_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int DEPTH_DEF = 4;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_PUSH = 3'd1;
    localparam logic [2:0] OP_POP  = 3'd2;
    localparam logic [2:0] OP_DUP  = 3'd3;
    localparam logic [2:0] OP_ADD  = 3'd4;
    localparam logic [2:0] OP_SUB  = 3'd5;
    localparam logic [2:0] OP_AND  = 3'd6;
    localparam logic [2:0] OP_SWAP = 3'd7;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PUSH_A = 3'd1;
    localparam logic [2:0] ST_POP_A  = 3'd2;
    localparam logic [2:0] ST_POP_B  = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_WB2    = 3'd5;

endpackage

// File: rtl/stack_op_sequencer_if.sv
// Command handshake between an opcode source (master) and the sequencer (slave).
interface stack_op_sequencer_if
    import stack_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);

    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_imm;

    modport master (output cmd_valid, output cmd_op, output cmd_imm, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_imm, output cmd_ready);

endinterface

// File: rtl/stack_op_alu.sv
// Combinational result for the binary stack ops; b is next-on-stack, a is top.
module stack_op_alu
    import stack_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = a;
        case (op)
            OP_ADD:  result = b + a;
            OP_SUB:  result = b - a;
            OP_AND:  result = b & a;
            default: result = a;
        endcase
    end

endmodule

// File: rtl/stack_op_sequencer.sv
// Sequences push/pop/write_data of a shift stack from one opcode per handshake,
// tracking occupancy so overflow and underflow are blocked and flagged.
module stack_op_sequencer
    import stack_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                         clock,
    input  logic                         reset_n,
    stack_op_sequencer_if.slave          cmd,
    output logic                         stack_push,
    output logic                         stack_pop,
    output logic [WIDTH-1:0]             stack_write_data,
    input  logic [WIDTH-1:0]             stack_read_data,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         err_overflow,
    output logic                         err_underflow
);

    localparam int DW = $clog2(DEPTH+1);
    localparam logic [DW-1:0] FULL = DW'(DEPTH);
    localparam logic [DW-1:0] ONE  = DW'(1);
    localparam logic [DW-1:0] TWO  = DW'(2);

    logic [2:0]       state;
    logic [2:0]       next_state;
    logic [2:0]       op_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] alu_result;
    logic             accept;
    logic             needs_two;
    logic             underflow_hit;
    logic             overflow_hit;

    assign cmd.cmd_ready = (state == ST_IDLE);
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;

    stack_op_alu #(.WIDTH(WIDTH)) u_alu (
        .op     (op_reg),
        .a      (a_reg),
        .b      (b_reg),
        .result (alu_result)
    );

    // Underflow takes priority, so a DUP on an empty stack only flags underflow.
    always_comb begin
        needs_two     = (cmd.cmd_op == OP_ADD) || (cmd.cmd_op == OP_SUB) ||
                        (cmd.cmd_op == OP_AND) || (cmd.cmd_op == OP_SWAP);
        underflow_hit = (((cmd.cmd_op == OP_POP) || (cmd.cmd_op == OP_DUP)) && (depth == '0)) ||
                        (needs_two && (depth < TWO));
        overflow_hit  = !underflow_hit &&
                        ((cmd.cmd_op == OP_PUSH) || (cmd.cmd_op == OP_DUP)) && (depth == FULL);
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (accept && !underflow_hit && !overflow_hit) begin
                    case (cmd.cmd_op)
                        OP_PUSH, OP_DUP:                      next_state = ST_PUSH_A;
                        OP_POP, OP_ADD, OP_SUB, OP_AND, OP_SWAP: next_state = ST_POP_A;
                        default:                              next_state = ST_IDLE;
                    endcase
                end
            end
            ST_PUSH_A: next_state = ST_IDLE;
            ST_POP_A:  next_state = (op_reg == OP_POP) ? ST_IDLE : ST_POP_B;
            ST_POP_B:  next_state = ST_WB;
            ST_WB:     next_state = (op_reg == OP_SWAP) ? ST_WB2 : ST_IDLE;
            ST_WB2:    next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // The stack drive is a pure function of state plus the latched operands.
    always_comb begin
        stack_push       = 1'b0;
        stack_pop        = 1'b0;
        stack_write_data = '0;
        case (state)
            ST_PUSH_A: begin
                stack_push       = 1'b1;
                stack_write_data = a_reg;
            end
            ST_POP_A, ST_POP_B: stack_pop = 1'b1;
            ST_WB: begin
                stack_push       = 1'b1;
                stack_write_data = (op_reg == OP_SWAP) ? a_reg : alu_result;
            end
            ST_WB2: begin
                stack_push       = 1'b1;
                stack_write_data = b_reg;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            op_reg        <= OP_NOP;
            a_reg         <= '0;
            b_reg         <= '0;
            depth         <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                op_reg <= cmd.cmd_op;
                a_reg  <= (cmd.cmd_op == OP_PUSH) ? cmd.cmd_imm : stack_read_data;
                if (underflow_hit) err_underflow <= 1'b1;
                if (overflow_hit)  err_overflow  <= 1'b1;
            end
            // During POP_B the stack presents the former second entry.
            if (state == ST_POP_B) b_reg <= stack_read_data;
            if (stack_push && (depth != FULL))
                depth <= depth + ONE;
            else if (stack_pop && (depth != '0))
                depth <= depth - ONE;
        end
    end

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Bench for stack_op_sequencer: a behavioural shift stack sits downstream,
// and an abstract stack model feeds a scoreboard of per-command outcomes.
module tb_stack_op_sequencer;
    import stack_pkg::*;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [15:0] top;
        logic [15:0] second;
        logic [2:0]  depth;
        logic [3:0]  busy;
        logic [7:0]  seq;
        logic        ovf;
        logic        unf;
    } rec_t;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              stack_push;
    logic              stack_pop;
    logic [WIDTH-1:0]  stack_write_data;
    logic [WIDTH-1:0]  stack_read_data;
    logic [2:0]        depth;
    logic              err_overflow;
    logic              err_underflow;
    logic [WIDTH-1:0]  stk [DEPTH];
    logic [WIDTH-1:0]  ref_stk [DEPTH];
    int                ref_depth;
    logic              ref_ovf;
    logic              ref_unf;
    rec_t              sb [$];
    rec_t              obs [$];
    int                n_checks;
    int                n_fail;

    always #5 clock = ~clock;

    stack_op_sequencer_if #(.WIDTH(WIDTH)) cmd ();

    stack_op_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .cmd              (cmd),
        .stack_push       (stack_push),
        .stack_pop        (stack_pop),
        .stack_write_data (stack_write_data),
        .stack_read_data  (stack_read_data),
        .depth            (depth),
        .err_overflow     (err_overflow),
        .err_underflow    (err_underflow)
    );

    // Downstream 4-entry shift stack, reset from ~reset_n like the real top level.
    assign stack_read_data = stk[0];
    always @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
        end else if (stack_push) begin
            stk[0] <= stack_write_data;
            for (int i = 1; i < DEPTH; i++) stk[i] <= stk[i-1];
        end else if (stack_pop) begin
            for (int i = 0; i < DEPTH-1; i++) stk[i] <= stk[i+1];
            stk[DEPTH-1] <= '0;
        end
    end

    task automatic model_push(input logic [15:0] v);
        for (int i = DEPTH-1; i > 0; i--) ref_stk[i] = ref_stk[i-1];
        ref_stk[0] = v;
    endtask

    task automatic model_pop();
        for (int i = 0; i < DEPTH-1; i++) ref_stk[i] = ref_stk[i+1];
        ref_stk[DEPTH-1] = '0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) ref_stk[i] = '0;
        ref_depth = 0;
        ref_ovf   = 1'b0;
        ref_unf   = 1'b0;
        sb.delete();
        obs.delete();
    endtask

    // Expected outcome per opcode; seq holds {push,pop} per busy cycle, oldest first.
    task automatic predict(input logic [2:0] op, input logic [15:0] imm);
        rec_t        e;
        logic [15:0] a, b, r;
        e = '0;
        case (op)
            OP_PUSH: begin
                if (ref_depth == DEPTH) ref_ovf = 1'b1;
                else begin model_push(imm); ref_depth++; e.busy = 1; e.seq = 8'b10; end
            end
            OP_POP: begin
                if (ref_depth == 0) ref_unf = 1'b1;
                else begin model_pop(); ref_depth--; e.busy = 1; e.seq = 8'b01; end
            end
            OP_DUP: begin
                if (ref_depth == 0) ref_unf = 1'b1;
                else if (ref_depth == DEPTH) ref_ovf = 1'b1;
                else begin model_push(ref_stk[0]); ref_depth++; e.busy = 1; e.seq = 8'b10; end
            end
            OP_ADD, OP_SUB, OP_AND: begin
                if (ref_depth < 2) ref_unf = 1'b1;
                else begin
                    a = ref_stk[0];
                    b = ref_stk[1];
                    r = (op == OP_ADD) ? 16'(b + a) : (op == OP_SUB) ? 16'(b - a) : (b & a);
                    model_pop(); model_pop(); model_push(r);
                    ref_depth--;
                    e.busy = 3; e.seq = 8'b010110;
                end
            end
            OP_SWAP: begin
                if (ref_depth < 2) ref_unf = 1'b1;
                else begin
                    a = ref_stk[0];
                    b = ref_stk[1];
                    model_pop(); model_pop(); model_push(a); model_push(b);
                    e.busy = 4; e.seq = 8'b01011010;
                end
            end
            default: ;
        endcase
        e.top    = ref_stk[0];
        e.second = ref_stk[1];
        e.depth  = 3'(ref_depth);
        e.ovf    = ref_ovf;
        e.unf    = ref_unf;
        sb.push_back(e);
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        model_clear();
    endtask

    // Drives one command and records what the sequencer and stack did with it.
    task automatic run_cmd(input logic [2:0] op, input logic [15:0] imm);
        rec_t o;
        int   waitc;
        bit   done;
        predict(op, imm);
        @(negedge clock);
        waitc = 0;
        while (!cmd.cmd_ready && waitc < 20) begin
            @(negedge clock);
            waitc++;
        end
        cmd.cmd_valid = 1'b1;
        cmd.cmd_op    = op;
        cmd.cmd_imm   = imm;
        @(posedge clock);
        o    = '0;
        done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (c == 0) begin
                cmd.cmd_valid = 1'b0;
                cmd.cmd_op    = 3'($urandom_range(7, 0));
                cmd.cmd_imm   = 16'($urandom);
            end
            if (cmd.cmd_ready) begin
                done = 1'b1;
                break;
            end
            o.busy = o.busy + 4'd1;
            o.seq  = {o.seq[5:0], stack_push, stack_pop};
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL cmd_timeout: cmd_ready still %b, required 1 within 20 cycles", cmd.cmd_ready);
        end
        o.top    = stack_read_data;
        o.second = stk[1];
        o.depth  = depth;
        o.ovf    = err_overflow;
        o.unf    = err_underflow;
        obs.push_back(o);
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (cmd.cmd_ready !== 1'b1 || depth !== 3'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_ready_depth: got ready=%b depth=%0d, required ready=1 depth=0", cmd.cmd_ready, depth);
        end
        n_checks++;
        if (err_overflow !== 1'b0 || err_underflow !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_flags: got ovf=%b unf=%b, required 0 0", err_overflow, err_underflow);
        end
        n_checks++;
        if (stack_push !== 1'b0 || stack_pop !== 1'b0 || stack_write_data !== 16'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_stack_drive: got push=%b pop=%b wdata=%h, required 0 0 0000", stack_push, stack_pop, stack_write_data);
        end
    endtask

    task automatic test_add();
        rec_t e, o;
        int   k = 0;
        apply_reset();
        run_cmd(OP_PUSH, 16'h0005);
        run_cmd(OP_PUSH, 16'h0003);
        run_cmd(OP_ADD,  16'h0000);
        run_cmd(OP_NOP,  16'h7777);
        while (sb.size() > 0 && obs.size() > 0) begin
            e = sb.pop_front();
            o = obs.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("[TB] FAIL add_cmd%0d: got %h required %h", k, o, e); end
            k++;
        end
    endtask

    task automatic test_sub_and();
        rec_t e, o;
        int   k = 0;
        apply_reset();
        run_cmd(OP_PUSH, 16'h0000);
        run_cmd(OP_PUSH, 16'h0001);
        run_cmd(OP_SUB,  16'h0000);
        run_cmd(OP_PUSH, 16'hF0F0);
        run_cmd(OP_PUSH, 16'h0FF0);
        run_cmd(OP_AND,  16'h0000);
        run_cmd(OP_DUP,  16'h0000);
        while (sb.size() > 0 && obs.size() > 0) begin
            e = sb.pop_front();
            o = obs.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("[TB] FAIL sub_and_cmd%0d: got %h required %h", k, o, e); end
            k++;
        end
    endtask

    task automatic test_swap();
        rec_t e, o;
        int   k = 0;
        apply_reset();
        run_cmd(OP_PUSH, 16'h0001);
        run_cmd(OP_PUSH, 16'h0002);
        run_cmd(OP_SWAP, 16'h0000);
        run_cmd(OP_POP,  16'h0000);
        while (sb.size() > 0 && obs.size() > 0) begin
            e = sb.pop_front();
            o = obs.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("[TB] FAIL swap_cmd%0d: got %h required %h", k, o, e); end
            k++;
        end
    endtask

    task automatic test_overflow();
        rec_t e, o;
        int   k = 0;
        apply_reset();
        run_cmd(OP_PUSH, 16'h1111);
        run_cmd(OP_PUSH, 16'h2222);
        run_cmd(OP_PUSH, 16'h3333);
        run_cmd(OP_PUSH, 16'h4444);
        run_cmd(OP_PUSH, 16'hAAAA);
        run_cmd(OP_DUP,  16'h0000);
        run_cmd(OP_POP,  16'h0000);
        while (sb.size() > 0 && obs.size() > 0) begin
            e = sb.pop_front();
            o = obs.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("[TB] FAIL overflow_cmd%0d: got %h required %h", k, o, e); end
            k++;
        end
    endtask

    task automatic test_underflow();
        rec_t e, o;
        int   k = 0;
        apply_reset();
        run_cmd(OP_PUSH, 16'h0011);
        run_cmd(OP_ADD,  16'h0000);
        run_cmd(OP_POP,  16'h0000);
        run_cmd(OP_POP,  16'h0000);
        run_cmd(OP_DUP,  16'h0000);
        run_cmd(OP_PUSH, 16'h0022);
        while (sb.size() > 0 && obs.size() > 0) begin
            e = sb.pop_front();
            o = obs.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("[TB] FAIL underflow_cmd%0d: got %h required %h", k, o, e); end
            k++;
        end
    endtask

    task automatic test_mid_reset();
        rec_t e, o;
        int   k = 0;
        apply_reset();
        run_cmd(OP_POP,  16'h0000);
        run_cmd(OP_PUSH, 16'h0007);
        run_cmd(OP_PUSH, 16'h0009);
        while (sb.size() > 0 && obs.size() > 0) begin
            e = sb.pop_front();
            o = obs.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("[TB] FAIL mid_reset_setup%0d: got %h required %h", k, o, e); end
            k++;
        end
        @(negedge clock);
        cmd.cmd_valid = 1'b1;
        cmd.cmd_op    = OP_ADD;
        @(posedge clock);
        @(negedge clock);
        cmd.cmd_valid = 1'b0;
        @(negedge clock);
        n_checks++;
        if (stack_pop !== 1'b1 || cmd.cmd_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_in_pop_b: got pop=%b ready=%b, required 1 0", stack_pop, cmd.cmd_ready);
        end
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        n_checks++;
        if (cmd.cmd_ready !== 1'b1 || depth !== 3'd0 || err_overflow !== 1'b0 || err_underflow !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_state: got ready=%b depth=%0d ovf=%b unf=%b, required 1 0 0 0",
                     cmd.cmd_ready, depth, err_overflow, err_underflow);
        end
        n_checks++;
        if (stack_push !== 1'b0 || stack_pop !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_drive: got push=%b pop=%b, required 0 0", stack_push, stack_pop);
        end
        @(negedge clock);
        n_checks++;
        if (stack_push !== 1'b0 || cmd.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_no_late_push: got push=%b ready=%b, required 0 1", stack_push, cmd.cmd_ready);
        end
        model_clear();
        run_cmd(OP_PUSH, 16'h1234);
        k = 0;
        while (sb.size() > 0 && obs.size() > 0) begin
            e = sb.pop_front();
            o = obs.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("[TB] FAIL mid_reset_after%0d: got %h required %h", k, o, e); end
            k++;
        end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        reset_n       = 1'b0;
        cmd.cmd_valid = 1'b0;
        cmd.cmd_op    = OP_NOP;
        cmd.cmd_imm   = '0;
        model_clear();
        test_reset();
        test_add();
        test_sub_and();
        test_swap();
        test_overflow();
        test_underflow();
        test_mid_reset();
        $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
